// File: rtl/aes_avalon_byte_slave.sv
// Byte-wide Avalon-MM responder: packs host writes into AES blocks for the core
// and streams buffered result blocks back one byte per read.
module aes_avalon_byte_slave #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset_sink_reset,
    input  logic                          avalon_slave_read,
    input  logic                          avalon_slave_write,
    input  logic [DATA_W-1:0]             avalon_slave_writedata,
    output logic [DATA_W-1:0]             avalon_slave_readdata,
    output logic [BLOCK_BYTES*DATA_W-1:0] blk_out_data,
    output logic                          blk_out_valid,
    input  logic                          blk_out_ready,
    input  logic [BLOCK_BYTES*DATA_W-1:0] blk_in_data,
    input  logic                          blk_in_valid,
    output logic                          blk_in_ready,
    output logic [7:0]                    led
);
    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
    localparam int unsigned BLK_W = BLOCK_BYTES * DATA_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_BYTES - 1);

    logic [BLK_W-1:0]  r_asm, r_out_data, r_rd_buf;
    logic [IDX_W-1:0]  r_wr_idx, r_rd_idx;
    logic              r_out_valid, r_rd_full, r_ovf, r_unf;
    logic [DATA_W-1:0] r_readdata;
    logic [7:0]        r_led;

    logic [BLK_W-1:0]  w_asm_wr, w_asm_nxt, w_out_data_nxt, w_rd_buf_nxt;
    logic [IDX_W-1:0]  w_wr_idx_nxt, w_rd_idx_nxt;
    logic              w_out_valid_nxt, w_rd_full_nxt, w_ovf_nxt, w_unf_nxt;
    logic [DATA_W-1:0] w_rd_byte, w_readdata_nxt;
    logic [7:0]        w_led_nxt;

    // Byte k lives at the MSB end: bits [BLK_W-1-k*DATA_W -: DATA_W].
    always_comb begin
        w_asm_wr  = r_asm;
        w_rd_byte = '0;
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if (r_wr_idx == IDX_W'(k))
                w_asm_wr[(BLOCK_BYTES-1-k)*DATA_W +: DATA_W] = avalon_slave_writedata;
            if (r_rd_idx == IDX_W'(k))
                w_rd_byte = r_rd_buf[(BLOCK_BYTES-1-k)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_asm_nxt       = r_asm;
        w_wr_idx_nxt    = r_wr_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid & ~blk_out_ready;
        w_ovf_nxt       = r_ovf;
        w_rd_buf_nxt    = r_rd_buf;
        w_rd_idx_nxt    = r_rd_idx;
        w_rd_full_nxt   = r_rd_full;
        w_readdata_nxt  = r_readdata;
        w_unf_nxt       = r_unf;

        if (avalon_slave_write) begin
            if (r_wr_idx != LAST) begin
                w_asm_nxt    = w_asm_wr;
                w_wr_idx_nxt = r_wr_idx + 1'b1;
            end else if (!r_out_valid || blk_out_ready) begin
                // The final byte bypasses the assembly register straight into the output.
                w_asm_nxt       = w_asm_wr;
                w_out_data_nxt  = w_asm_wr;
                w_out_valid_nxt = 1'b1;
                w_wr_idx_nxt    = '0;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end

        if (avalon_slave_read) begin
            if (r_rd_full) begin
                w_readdata_nxt = w_rd_byte;
                w_rd_idx_nxt   = r_rd_idx + 1'b1;
                if (r_rd_idx == LAST)
                    w_rd_full_nxt = 1'b0;
            end else begin
                w_readdata_nxt = '0;
                w_unf_nxt      = 1'b1;
            end
        end

        if (blk_in_valid && !r_rd_full) begin
            w_rd_buf_nxt  = blk_in_data;
            w_rd_idx_nxt  = '0;
            w_rd_full_nxt = 1'b1;
        end

        w_led_nxt = {4'(w_wr_idx_nxt), w_rd_full_nxt, w_out_valid_nxt, w_ovf_nxt, w_unf_nxt};
    end

    always_ff @(posedge clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            r_asm       <= '0;
            r_wr_idx    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_rd_buf    <= '0;
            r_rd_idx    <= '0;
            r_rd_full   <= 1'b0;
            r_readdata  <= '0;
            r_unf       <= 1'b0;
            r_led       <= '0;
        end else begin
            r_asm       <= w_asm_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_ovf       <= w_ovf_nxt;
            r_rd_buf    <= w_rd_buf_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_rd_full   <= w_rd_full_nxt;
            r_readdata  <= w_readdata_nxt;
            r_unf       <= w_unf_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign avalon_slave_readdata = r_readdata;
    assign blk_out_data          = r_out_data;
    assign blk_out_valid         = r_out_valid;
    assign blk_in_ready          = ~r_rd_full;
    assign led                   = r_led;
endmodule
